// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive engine.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // cfg_data_len encodings
   localparam logic [1:0] LEN_5 = 2'b00;
   localparam logic [1:0] LEN_6 = 2'b01;
   localparam logic [1:0] LEN_7 = 2'b10;
   localparam logic [1:0] LEN_8 = 2'b11;

   // Number of data bits carried by a frame for a given length code.
   function automatic logic [3:0] data_bits(input logic [1:0] len);
      case (len)
         LEN_5:   return 4'd5;
         LEN_6:   return 4'd6;
         LEN_7:   return 4'd7;
         default: return 4'd8;
      endcase
   endfunction

   // data_xor is the running XOR of the data bits; a mismatch against the
   // requested sense (odd/even) flags a parity error.
   function automatic logic parity_err_calc(input logic data_xor,
                                            input logic par_bit,
                                            input logic odd);
      return (data_xor ^ par_bit) != odd;
   endfunction

   // 2-of-3 vote.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/dff.sv
// Shared parametrised register with asynchronous active-high reset.
module dff #(
   parameter int           W       = 1,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // plain register, reset to RST_VAL
   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= RST_VAL;
      else     q <= d;
   end

endmodule

// File: rtl/uart_rx_sync.sv
// Synchroniser for the asynchronous serial line plus falling-edge detect.
// All flops reset to 1 so a line that is idle at reset release never
// looks like a start edge.
module uart_rx_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic pclk,
   input  logic preset,
   input  logic uart_rxd,
   output logic rxd_s,
   output logic rxd_fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxd_d;

   // metastability chain and one-cycle-delayed copy for edge detect
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         sync_q <= '1;
         rxd_d  <= 1'b1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rxd};
         rxd_d  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rxd_s    = sync_q[SYNC_STAGES-1];
   assign rxd_fall = rxd_d & ~rxd_s;

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start validation, oversample timing, data shift,
// parity/stop checking and a valid/ready result handshake.
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a
// 2-of-3 vote over three consecutive oversample ticks.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a synchronised high->low edge with rx_en high
// ST_START  | timing to mid start bit, reject false starts
// ST_DATA   | shifting in cfg_data_len+5 data bits, LSB first
// ST_PARITY | sampling the parity bit
// ST_STOP   | sampling one or two stop bits, result emitted on the last
module uart_rx_engine
   import uart_rx_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              rx_en,
   input  logic              uart_rxd,
   input  logic              baud_tick,
   input  logic [1:0]        cfg_data_len,
   input  logic              cfg_parity_en,
   input  logic              cfg_parity_odd,
   input  logic              cfg_stop2,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              parity_err,
   output logic              frame_err,
   output logic              overrun_err,
   output logic              rx_busy
);

   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // With voting the decision lands one tick after the nominal sample
   // point. Only the start decision moves; later bits keep a full
   // OVERSAMPLE-tick period from it, so every decision is one tick later
   // than in the single-sample build without accumulating drift.
`ifdef UART_RX_MAJORITY_EN
   localparam int PT_SHIFT = 1;
`else
   localparam int PT_SHIFT = 0;
`endif
   localparam logic [OS_W-1:0] START_PT = OS_W'(OVERSAMPLE / 2 - 1 + PT_SHIFT);
   localparam logic [OS_W-1:0] BIT_PT   = OS_W'(OVERSAMPLE - 1);

   rx_state_t         state, state_nxt;
   logic [2:0]        state_raw;
   logic [OS_W-1:0]   os_cnt_q;
   logic [BIT_W-1:0]  bit_cnt_q;
   logic [BIT_W-1:0]  last_bit;
   logic              stop_cnt_q;
   logic [DATA_W-1:0] shift_q;
   logic              par_acc_q;
   logic              par_err_q;
   logic              frm_err_q;
   logic              frm_err_fin;
   logic [1:0]        len_q;
   logic              par_en_q;
   logic              par_odd_q;
   logic              stop2_q;
   logic              rxd_s;
   logic              rxd_fall;
   logic              bit_s;
   logic              tick_pt;
   logic              start_go;
   logic              frame_done;

   uart_rx_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .pclk     (pclk),
      .preset   (preset),
      .uart_rxd (uart_rxd),
      .rxd_s    (rxd_s),
      .rxd_fall (rxd_fall)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] vote_q;

   // history of the two previous tick samples for the 2-of-3 vote
   always_ff @(posedge pclk or posedge preset) begin
      if (preset)         vote_q <= 2'b11;
      else if (baud_tick) vote_q <= {vote_q[0], rxd_s};
   end

   assign bit_s = maj3(vote_q[1], vote_q[0], rxd_s);
`else
   assign bit_s = rxd_s;
`endif

   dff #(
      .W       (3),
      .RST_VAL (3'(ST_IDLE))
   ) u_state (
      .clk (pclk),
      .rst (preset),
      .d   (state_nxt),
      .q   (state_raw)
   );

   assign state       = rx_state_t'(state_raw);
   assign rx_busy     = (state != ST_IDLE);
   assign last_bit    = BIT_W'(data_bits(len_q) - 4'd1);
   assign tick_pt     = baud_tick &&
                        (os_cnt_q == ((state == ST_START) ? START_PT : BIT_PT));
   assign frm_err_fin = frm_err_q | ~bit_s;

   // next-state and frame-completion strobe
   always_comb begin
      state_nxt  = state;
      start_go   = 1'b0;
      frame_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rxd_fall) begin
               state_nxt = ST_START;
               start_go  = 1'b1;
            end
         end
         ST_START: begin
            if (tick_pt) state_nxt = bit_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (tick_pt && (bit_cnt_q == last_bit))
               state_nxt = par_en_q ? ST_PARITY : ST_STOP;
         end
         ST_PARITY: begin
            if (tick_pt) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (tick_pt && (!stop2_q || stop_cnt_q)) begin
               state_nxt  = ST_IDLE;
               frame_done = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (!rx_en) begin
         state_nxt  = ST_IDLE;
         start_go   = 1'b0;
         frame_done = 1'b0;
      end
   end

   // oversample/bit counters, data shifter and per-frame status
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_acc_q  <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         len_q      <= LEN_5;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         stop2_q    <= 1'b0;
      end else if (start_go) begin
         os_cnt_q   <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         shift_q    <= '0;
         par_acc_q  <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         len_q      <= cfg_data_len;
         par_en_q   <= cfg_parity_en;
         par_odd_q  <= cfg_parity_odd;
         stop2_q    <= cfg_stop2;
      end else if ((state != ST_IDLE) && baud_tick) begin
         if (tick_pt) os_cnt_q <= '0;
         else         os_cnt_q <= os_cnt_q + OS_W'(1);
         if (tick_pt) begin
            case (state)
               ST_START: bit_cnt_q <= '0;
               ST_DATA: begin
                  shift_q[bit_cnt_q] <= bit_s;
                  par_acc_q          <= par_acc_q ^ bit_s;
                  bit_cnt_q          <= bit_cnt_q + BIT_W'(1);
               end
               ST_PARITY: par_err_q <= parity_err_calc(par_acc_q, bit_s, par_odd_q);
               ST_STOP: begin
                  frm_err_q  <= frm_err_fin;
                  stop_cnt_q <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // result handshake; a new result in the acceptance cycle wins, and a
   // result arriving while the old one is still unread is dropped
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         parity_err  <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (frame_done && rx_valid && !rx_ready) begin
            overrun_err <= 1'b1;
         end else if (frame_done) begin
            rx_valid   <= 1'b1;
            rx_data    <= shift_q;
            parity_err <= par_err_q;
            frame_err  <= frm_err_fin;
         end else if (rx_valid && rx_ready) begin
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed bench for uart_rx_engine (OVERSAMPLE=16, DATA_W=8).
module tb_uart_rx_engine;

   localparam int OS      = 16;
   localparam int TDIV    = 4;
   localparam int BIT_CLK = OS * TDIV;

   logic       pclk           = 1'b0;
   logic       preset         = 1'b1;
   logic       rx_en          = 1'b0;
   logic       uart_rxd       = 1'b1;
   logic       baud_tick      = 1'b0;
   logic [1:0] cfg_data_len   = 2'b11;
   logic       cfg_parity_en  = 1'b0;
   logic       cfg_parity_odd = 1'b0;
   logic       cfg_stop2      = 1'b0;
   logic       rx_ready       = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun_err;
   logic       rx_busy;

   int checks = 0;
   int errors = 0;
   int valid_hi_cnt = 0;
   int ovr_cnt = 0;
   int rise_ok_cnt = 0;
   int div = 0;
   logic valid_prev = 1'b0;
   logic busy_prev = 1'b0;
   logic [9:0] acc_q[$];

   uart_rx_engine #(
      .OVERSAMPLE  (OS),
      .DATA_W      (8),
      .SYNC_STAGES (2)
   ) dut (
      .pclk           (pclk),
      .preset         (preset),
      .rx_en          (rx_en),
      .uart_rxd       (uart_rxd),
      .baud_tick      (baud_tick),
      .cfg_data_len   (cfg_data_len),
      .cfg_parity_en  (cfg_parity_en),
      .cfg_parity_odd (cfg_parity_odd),
      .cfg_stop2      (cfg_stop2),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_ready       (rx_ready),
      .parity_err     (parity_err),
      .frame_err      (frame_err),
      .overrun_err    (overrun_err),
      .rx_busy        (rx_busy)
   );

   always #5 pclk = ~pclk;

   always @(negedge pclk) begin
      div = (div + 1) % TDIV;
      baud_tick = (div == 0);
   end

   // records accepted results and handshake timing
   always @(negedge pclk) begin
      if (rx_valid) valid_hi_cnt++;
      if (overrun_err) ovr_cnt++;
      if (rx_valid && rx_ready) acc_q.push_back({frame_err, parity_err, rx_data});
      if (rx_valid && !valid_prev && busy_prev && !rx_busy) rise_ok_cnt++;
      valid_prev = rx_valid;
      busy_prev  = rx_busy;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge pclk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      uart_rxd = b;
      wait_clk(BIT_CLK);
   endtask

   task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                             input logic par_bit, input logic stop_a, input logic stop_b,
                             input logic two_stop);
      send_bit(1'b0);
      for (int i = 0; i < nbits; i++) send_bit(d[i]);
      if (par_en) send_bit(par_bit);
      send_bit(stop_a);
      if (two_stop) send_bit(stop_b);
      uart_rxd = 1'b1;
   endtask

   task automatic set_cfg(input logic [1:0] len, input logic pen, input logic podd,
                          input logic s2);
      cfg_data_len   = len;
      cfg_parity_en  = pen;
      cfg_parity_odd = podd;
      cfg_stop2      = s2;
   endtask

   task automatic pop_result(output logic [9:0] r);
      if (acc_q.size() > 0) r = acc_q.pop_front();
      else r = 'x;
   endtask

   task automatic test_reset;
      preset = 1'b1;
      wait_clk(3);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
      checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b exp 0", overrun_err); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
      preset = 1'b0;
      rx_en  = 1'b1;
      wait_clk(8);
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b exp 0", rx_busy); end
   endtask

   task automatic test_8n1;
      int v0, r0;
      logic [9:0] r;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      rx_ready = 1'b1;
      acc_q.delete();
      v0 = valid_hi_cnt;
      r0 = rise_ok_cnt;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_clk(BIT_CLK);
      checks++; if (acc_q.size() !== 1) begin errors++; $display("FAIL 8n1_count got %0d exp 1", acc_q.size()); end
      pop_result(r);
      checks++; if (r !== {2'b00, 8'hA5}) begin errors++; $display("FAIL 8n1_result got %h exp %h", r, {2'b00, 8'hA5}); end
      checks++; if (valid_hi_cnt - v0 !== 1) begin errors++; $display("FAIL 8n1_valid_cycles got %0d exp 1", valid_hi_cnt - v0); end
      checks++; if (rise_ok_cnt - r0 !== 1) begin errors++; $display("FAIL 8n1_latency got %0d exp 1", rise_ok_cnt - r0); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL 8n1_busy got %b exp 0", rx_busy); end
   endtask

   task automatic test_parity;
      logic [9:0] r;
      set_cfg(2'b10, 1'b1, 1'b0, 1'b0);
      acc_q.delete();
      send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      wait_clk(BIT_CLK);
      pop_result(r);
      checks++; if (r !== {2'b01, 8'h35}) begin errors++; $display("FAIL 7e1_bad_par got %h exp %h", r, {2'b01, 8'h35}); end
      send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_clk(BIT_CLK);
      pop_result(r);
      checks++; if (r !== {2'b00, 8'h35}) begin errors++; $display("FAIL 7e1_good_par got %h exp %h", r, {2'b00, 8'h35}); end
   endtask

   task automatic test_glitch;
      int v0;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      acc_q.delete();
      v0 = valid_hi_cnt;
      uart_rxd = 1'b0;
      wait_clk(8);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_rise got %b exp 1", rx_busy); end
      wait_clk(4 * TDIV - 8);
      uart_rxd = 1'b1;
      wait_clk(BIT_CLK);
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_fall got %b exp 0", rx_busy); end
      checks++; if (valid_hi_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_no_valid got %0d exp 0", valid_hi_cnt - v0); end
   endtask

   task automatic test_overrun;
      int o0;
      logic [9:0] r;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      acc_q.delete();
      rx_ready = 1'b0;
      o0 = ovr_cnt;
      send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_clk(BIT_CLK);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held got %b exp 1", rx_valid); end
      checks++; if (rx_data !== 8'h11) begin errors++; $display("FAIL ovr_data_kept got %h exp 11", rx_data); end
      checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - o0); end
      rx_ready = 1'b1;
      wait_clk(1);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b exp 0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL ovr_data_drop got %h exp 00", rx_data); end
      pop_result(r);
      checks++; if (r !== {2'b00, 8'h11}) begin errors++; $display("FAIL ovr_accepted got %h exp %h", r, {2'b00, 8'h11}); end
      checks++; if (acc_q.size() !== 0) begin errors++; $display("FAIL ovr_single_accept got %0d exp 0", acc_q.size()); end
   endtask

   task automatic test_frame_err;
      logic [9:0] r;
      set_cfg(2'b00, 1'b1, 1'b1, 1'b1);
      acc_q.delete();
      send_frame(8'h1B, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      send_bit(1'b1);
      pop_result(r);
      checks++; if (r !== {2'b10, 8'h1B}) begin errors++; $display("FAIL 5o2_stop_low got %h exp %h", r, {2'b10, 8'h1B}); end
      send_frame(8'h0A, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_clk(BIT_CLK);
      pop_result(r);
      checks++; if (r !== {2'b00, 8'h0A}) begin errors++; $display("FAIL 5o2_clean got %h exp %h", r, {2'b00, 8'h0A}); end
   endtask

   task automatic test_abort;
      int v0;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      acc_q.delete();
      v0 = valid_hi_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b exp 1", rx_busy); end
      rx_en = 1'b0;
      wait_clk(1);
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL abort_idle_next got %b exp 0", rx_busy); end
      for (int i = 0; i < 6; i++) send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      rx_en = 1'b1;
      wait_clk(BIT_CLK);
      checks++; if (valid_hi_cnt - v0 !== 0) begin errors++; $display("FAIL abort_no_valid got %0d exp 0", valid_hi_cnt - v0); end
   endtask

   task automatic test_back_to_back;
      logic [9:0] r;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      acc_q.delete();
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      wait_clk(BIT_CLK);
      checks++; if (acc_q.size() !== 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", acc_q.size()); end
      pop_result(r);
      checks++; if (r !== {2'b00, 8'h3C}) begin errors++; $display("FAIL b2b_first got %h exp %h", r, {2'b00, 8'h3C}); end
      pop_result(r);
      checks++; if (r !== {2'b00, 8'hC3}) begin errors++; $display("FAIL b2b_second got %h exp %h", r, {2'b00, 8'hC3}); end
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_majority;
      logic [9:0] r;
      logic [7:0] d;
      d = 8'h5A;
      set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
      acc_q.delete();
      send_bit(1'b0);
      send_bit(d[0]);
      uart_rxd = 1'b1;
      wait_clk(BIT_CLK / 2 - 2);
      uart_rxd = 1'b0;
      wait_clk(TDIV);
      uart_rxd = 1'b1;
      wait_clk(BIT_CLK / 2 + 2 - TDIV);
      for (int i = 2; i < 8; i++) send_bit(d[i]);
      send_bit(1'b1);
      wait_clk(BIT_CLK);
      pop_result(r);
      checks++; if (r !== {2'b00, 8'h5A}) begin errors++; $display("FAIL maj_glitch got %h exp %h", r, {2'b00, 8'h5A}); end
   endtask
`endif

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_glitch();
      test_overrun();
      test_frame_err();
      test_abort();
      test_back_to_back();
`ifdef UART_RX_MAJORITY_EN
      test_majority();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- Parametrised successor to the receive FSM. One block contains start validation, oversample timing, data shifting, parity and stop checking, and a valid/ready output handshake.
- Frame format is configurable: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
- Sits between the baud generator (oversample tick) and the RX FIFO / APB register block.

Parameters:
- OVERSAMPLE, 16, baud_tick pulses per bit; even, >=8.
- DATA_W, 8, maximum data width, and the width of rx_data.
- SYNC_STAGES, 2, flops in the uart_rxd synchroniser; >=2.

Ports:
- pclk  input  1  clock.
- preset  input  1  asynchronous active-high reset.
- rx_en  input  1  receiver enable; low aborts any frame.
- uart_rxd  input  1  serial line, asynchronous, idle high.
- baud_tick  input  1  single-cycle oversample strobe.
- cfg_data_len  input  2  data bits: 00=5, 01=6, 10=7, 11=8.
- cfg_parity_en  input  1  parity bit present.
- cfg_parity_odd  input  1  1=odd, 0=even.
- cfg_stop2  input  1  two stop bits.
- rx_data  output  DATA_W  received word, LSB-first on line, right-justified, unused MSBs zero.
- rx_valid  output  1  rx_data/status valid; held until accepted.
- rx_ready  input  1  consumer accepts when rx_valid&rx_ready.
- parity_err  output  1  qualifies rx_data; valid with rx_valid.
- frame_err  output  1  any stop bit sampled low; valid with rx_valid.
- overrun_err  output  1  one-cycle pulse: frame lost.
- rx_busy  output  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchroniser flops preset to 1.
- Config inputs are sampled in IDLE only. They are held stable from start detection until the end of the frame.
- States: IDLE, START, DATA, PARITY, STOP.
- os_cnt advances only on baud_tick.
- IDLE -> START: rx_en high and synchronised falling edge on rxd; os_cnt cleared.
- START: on the tick where os_cnt==OVERSAMPLE/2-1, sample rxd.
  - Low -> DATA, os_cnt=0, bit_cnt=0.
  - High -> IDLE (false start, no output).
- DATA/PARITY/STOP: sample on the tick where os_cnt==OVERSAMPLE-1, then os_cnt=0. This gives a mid-bit sample.
- DATA: shift in LSB-first. After cfg_data_len+5 bits -> PARITY if cfg_parity_en, else STOP.
- PARITY: parity_err = (XOR of data bits ^ sampled bit) != cfg_parity_odd.
- STOP: one sample, or two if cfg_stop2. frame_err if any stop sample is low.
- After the final stop sample: -> IDLE in the same cycle. The result is registered and rx_valid rises the next pclk.
- A line held low after a frame error does not retrigger. IDLE needs a high-then-low edge.
- Handshake:
  - rx_valid, rx_data and the error flags stay stable until rx_valid&rx_ready.
  - They drop the cycle after acceptance unless a new result is delivered in that same cycle; the new result wins.
- Overrun: a frame completes while rx_valid=1 and rx_ready=0. Then the old data is kept, the new frame is discarded, and overrun_err pulses 1 cycle.
- rx_en low in any state: -> IDLE next pclk, partial frame discarded, no rx_valid. A pending rx_valid is unaffected.
- baud_tick and rx_ready are both honoured in the same cycle.
- Latency: rx_valid 1 pclk after the final stop-bit sample tick.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every bit sample (start, data, parity, stop) is a 2-of-3 majority of the synchronised rxd at the ticks os_cnt==target-1, target, target+1. The decision is taken at target+1, so every sample point shifts one tick later.
- Undefined: a single sample at target.
- Port list is identical in both builds.

Decomposition:
- Package uart_rx_pkg holds:
  - the state enum;
  - cfg_data_len encoding localparams;
  - the function mapping cfg_data_len to bit count;
  - a parity-compute function.
- Sub-module uart_rx_sync: SYNC_STAGES synchroniser plus registered falling-edge detect, reset to 1.
- State register uses the shared dff.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5, rx_ready=1 -> rx_valid one cycle, rx_data=0xA5, parity_err=0, frame_err=0.
- 7E1, send 0x35 with a wrong parity bit -> rx_data=0x35, parity_err=1. Same frame with correct parity -> parity_err=0.
- Low glitch of 4 ticks on idle line -> START then IDLE, no rx_valid, rx_busy falls.
- rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err pulses once. Assert rx_ready -> 0x11 accepted, rx_valid drops.
- 5O2, second stop bit driven low, data 0x1B -> rx_data=0x1B, frame_err=1. Next frame 0x0A clean -> frame_err=0.
- rx_en dropped mid-DATA -> IDLE next cycle, no rx_valid. With UART_RX_MAJORITY_EN, a 1-tick glitch at the mid-bit of data 0x5A -> rx_data=0x5A.
